wash_sequencer: RTL and testbench

- Wash-cycle controller that produces the three 6-bit display values consumed by the seven-segment display stage.
- Display value codes: total remaining time, current-phase remaining time, water level.
- Sequences a fixed program driven by a 1 Hz tick: fill, wash, drain, fill, rinse, drain, spin.
- Values 0–54 are shown as decimal; codes 55–61 select text patterns (55 blank, 56 "88", 57 "PA").

---
 rtl/wash_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_wash_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// Wash-cycle controller: sequences fill/wash/drain/fill/rinse/drain/spin on a
// 1 Hz tick and produces the three 6-bit display codes for the segment stage.
module wash_sequencer #(
   parameter int WAT_FULL = 5,
   parameter int WASH_T   = 9,
   parameter int RINSE_T  = 6,
   parameter int SPIN_T   = 5,
   parameter int LAMP_T   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uPower,
   input  logic       uStart,
   input  logic       uTick,
   input  logic       uLidOpen,
   output logic [5:0] yTot,
   output logic [5:0] yCur,
   output logic [5:0] yWat,
   output logic [3:0] yPhase,
   output logic       yDone
);

   typedef enum logic [3:0] {
      S_OFF    = 4'd0,
      S_LAMP   = 4'd1,
      S_IDLE   = 4'd2,
      S_FILL1  = 4'd3,
      S_WASH   = 4'd4,
      S_DRAIN1 = 4'd5,
      S_FILL2  = 4'd6,
      S_RINSE  = 4'd7,
      S_DRAIN2 = 4'd8,
      S_SPIN   = 4'd9,
      S_DONE   = 4'd10
   } state_t;

   localparam logic [5:0] TOTAL   = 6'(4*WAT_FULL + WASH_T + RINSE_T + SPIN_T);
   localparam logic [5:0] D_BLANK = 6'd55;
   localparam logic [5:0] D_LAMP  = 6'd56;
   localparam logic [5:0] D_PAUSE = 6'd57;

   function automatic state_t f_next(input state_t s);
      state_t n;
      n = S_DONE;
      case (s)
         S_FILL1:  n = S_WASH;
         S_WASH:   n = S_DRAIN1;
         S_DRAIN1: n = S_FILL2;
         S_FILL2:  n = S_RINSE;
         S_RINSE:  n = S_DRAIN2;
         S_DRAIN2: n = S_SPIN;
         default:  n = S_DONE;
      endcase
      return n;
   endfunction

   function automatic logic [5:0] f_dur(input state_t s);
      logic [5:0] d;
      d = 6'd0;
      case (s)
         S_FILL1, S_DRAIN1,
         S_FILL2, S_DRAIN2: d = 6'(WAT_FULL);
         S_WASH:            d = 6'(WASH_T);
         S_RINSE:           d = 6'(RINSE_T);
         S_SPIN:            d = 6'(SPIN_T);
         default:           d = 6'd0;
      endcase
      return d;
   endfunction

   state_t     r_state;
   logic       r_pause;
   logic [5:0] r_tot;
   logic [5:0] r_cnt;
   logic [5:0] r_wat;

   state_t     w_state;
   state_t     w_nxt;
   logic       w_pause;
   logic [5:0] w_tot;
   logic [5:0] w_cnt;
   logic [5:0] w_wat;
   logic       w_done;
   logic [5:0] w_dtot;
   logic [5:0] w_dcur;
   logic [5:0] w_dwat;

   always_comb begin
      w_state = r_state;
      w_pause = r_pause;
      w_tot   = r_tot;
      w_cnt   = r_cnt;
      w_wat   = r_wat;
      w_done  = 1'b0;
      w_nxt   = f_next(r_state);
      if (!uPower) begin
         w_state = S_OFF;
         w_pause = 1'b0;
         w_tot   = 6'd0;
         w_cnt   = 6'd0;
         w_wat   = 6'd0;
      end else begin
         case (r_state)
            S_OFF: begin
               w_state = S_LAMP;
               w_cnt   = 6'(LAMP_T);
            end
            S_LAMP: begin
               if (uTick) begin
                  if (r_cnt == 6'd1) begin
                     w_state = S_IDLE;
                     w_tot   = TOTAL;
                     w_cnt   = 6'd0;
                     w_wat   = 6'd0;
                  end else begin
                     w_cnt = r_cnt - 6'd1;
                  end
               end
            end
            S_IDLE: begin
               if (uStart && !uLidOpen) begin
                  w_state = S_FILL1;
                  w_cnt   = 6'(WAT_FULL);
                  w_pause = 1'b0;
               end
            end
            S_DONE: begin
               if (uStart) begin
                  w_state = S_IDLE;
                  w_tot   = TOTAL;
                  w_cnt   = 6'd0;
                  w_wat   = 6'd0;
               end
            end
            default: begin
               // lid and start both consume the cycle's tick
               if (uLidOpen) begin
                  w_pause = 1'b1;
               end else if (uStart) begin
                  w_pause = ~r_pause;
               end else if (uTick && !r_pause) begin
                  w_tot = r_tot - 6'd1;
                  if (r_state == S_FILL1 || r_state == S_FILL2)
                     w_wat = r_wat + 6'd1;
                  else if (r_state == S_DRAIN1 || r_state == S_DRAIN2)
                     w_wat = r_wat - 6'd1;
                  if (r_cnt == 6'd1) begin
                     w_state = w_nxt;
                     w_cnt   = f_dur(w_nxt);
                     w_done  = (w_nxt == S_DONE);
                  end else begin
                     w_cnt = r_cnt - 6'd1;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      w_dtot = w_tot;
      w_dcur = w_pause ? D_PAUSE : w_cnt;
      w_dwat = w_wat;
      if (w_state == S_OFF) begin
         w_dtot = D_BLANK;
         w_dcur = D_BLANK;
         w_dwat = D_BLANK;
      end else if (w_state == S_LAMP) begin
         w_dtot = D_LAMP;
         w_dcur = D_LAMP;
         w_dwat = D_LAMP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_OFF;
         r_pause <= 1'b0;
         r_tot   <= 6'd0;
         r_cnt   <= 6'd0;
         r_wat   <= 6'd0;
         yTot    <= D_BLANK;
         yCur    <= D_BLANK;
         yWat    <= D_BLANK;
         yPhase  <= 4'd0;
         yDone   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_pause <= w_pause;
         r_tot   <= w_tot;
         r_cnt   <= w_cnt;
         r_wat   <= w_wat;
         yTot    <= w_dtot;
         yCur    <= w_dcur;
         yWat    <= w_dwat;
         yPhase  <= 4'(w_state);
         yDone   <= w_done;
      end
   end

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: vector table for power-up and early
// phases, then hand sequences for pause, lid, power-drop and full runs.
module tb_wash_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       uPower;
   logic       uStart;
   logic       uTick;
   logic       uLidOpen;
   logic [5:0] yTot;
   logic [5:0] yCur;
   logic [5:0] yWat;
   logic [3:0] yPhase;
   logic       yDone;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic  r, p, s, t, l;
      int    tot, cur, wat, ph, dn;
      string nm;
   } vec_t;

   vec_t tbl[$];

   // cumulative tick count at which each running phase ends
   localparam int ENDS[7] = '{5, 14, 19, 24, 30, 35, 40};

   wash_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .uPower   (uPower),
      .uStart   (uStart),
      .uTick    (uTick),
      .uLidOpen (uLidOpen),
      .yTot     (yTot),
      .yCur     (yCur),
      .yWat     (yWat),
      .yPhase   (yPhase),
      .yDone    (yDone)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, p, s, t, l,
                      input int tot, cur, wat, ph, dn,
                      input string nm);
      vec_t v;
      v.r = r; v.p = p; v.s = s; v.t = t; v.l = l;
      v.tot = tot; v.cur = cur; v.wat = wat; v.ph = ph; v.dn = dn;
      v.nm = nm;
      tbl.push_back(v);
   endtask

   task automatic apply(input logic r, p, s, t, l);
      rst = r; uPower = p; uStart = s; uTick = t; uLidOpen = l;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm,
                      input int tot, cur, wat, ph, dn);
      checks++;
      if (int'(yTot) != tot || int'(yCur) != cur || int'(yWat) != wat ||
          int'(yPhase) != ph || int'(yDone) != dn) begin
         errors++;
         $display("FAIL %s: got tot=%0d cur=%0d wat=%0d ph=%0d done=%0d, want tot=%0d cur=%0d wat=%0d ph=%0d done=%0d",
                  nm, yTot, yCur, yWat, yPhase, yDone, tot, cur, wat, ph, dn);
      end
   endtask

   function automatic void exp_at(input int k,
                                  output int tot, cur, wat, ph);
      tot = 40 - k;
      ph  = 10;
      cur = 0;
      for (int i = 0; i < 7; i++) begin
         if (k < ENDS[i]) begin
            ph  = 3 + i;
            cur = ENDS[i] - k;
            break;
         end
      end
      if (k <= 5)       wat = k;
      else if (k <= 14) wat = 5;
      else if (k <= 19) wat = 19 - k;
      else if (k <= 24) wat = k - 19;
      else if (k <= 30) wat = 5;
      else if (k <= 35) wat = 35 - k;
      else              wat = 0;
   endfunction

   task automatic run_ticks(input int from, input int to, input string nm);
      int et, ec, ew, ep;
      for (int k = from; k <= to; k++) begin
         apply(0, 1, 0, 1, 0);
         exp_at(k, et, ec, ew, ep);
         chk($sformatf("%s_k%0d", nm, k), et, ec, ew, ep, (k == 40) ? 1 : 0);
      end
   endtask

   initial begin
      rst = 1; uPower = 0; uStart = 0; uTick = 0; uLidOpen = 0;

      add(1, 0, 0, 0, 0, 55, 55, 55, 0, 0, "reset");
      add(0, 0, 0, 0, 0, 55, 55, 55, 0, 0, "off_hold");
      add(0, 1, 0, 0, 0, 56, 56, 56, 1, 0, "lamp_entry");
      add(0, 1, 0, 0, 0, 56, 56, 56, 1, 0, "lamp_hold");
      add(0, 1, 0, 1, 0, 56, 56, 56, 1, 0, "lamp_tick1");
      add(0, 1, 0, 1, 0, 40,  0,  0, 2, 0, "idle_entry");
      add(0, 1, 1, 0, 1, 40,  0,  0, 2, 0, "idle_start_lid");
      add(0, 1, 0, 1, 0, 40,  0,  0, 2, 0, "idle_tick");
      add(0, 1, 1, 0, 0, 40,  5,  0, 3, 0, "fill1_entry");
      add(0, 1, 0, 1, 0, 39,  4,  1, 3, 0, "fill1_t1");
      add(0, 1, 0, 1, 0, 38,  3,  2, 3, 0, "fill1_t2");
      add(0, 1, 1, 1, 0, 38, 57,  2, 3, 0, "start_tick_pause");
      add(0, 1, 0, 1, 0, 38, 57,  2, 3, 0, "paused_tick");
      add(0, 1, 1, 0, 0, 38,  3,  2, 3, 0, "resume_cnt3");
      add(0, 1, 0, 1, 0, 37,  2,  3, 3, 0, "fill1_t3");
      add(0, 1, 0, 1, 0, 36,  1,  4, 3, 0, "fill1_t4");
      add(0, 1, 0, 1, 0, 35,  9,  5, 4, 0, "wash_entry");
      add(0, 1, 0, 1, 1, 35, 57,  5, 4, 0, "lid_tick_dropped");
      add(0, 1, 0, 1, 0, 35, 57,  5, 4, 0, "lid_closed_paused");
      add(0, 1, 1, 0, 0, 35,  9,  5, 4, 0, "resume_wash");

      foreach (tbl[i]) begin
         apply(tbl[i].r, tbl[i].p, tbl[i].s, tbl[i].t, tbl[i].l);
         chk(tbl[i].nm, tbl[i].tot, tbl[i].cur, tbl[i].wat,
             tbl[i].ph, tbl[i].dn);
      end

      run_ticks(6, 10, "wash");
      apply(0, 1, 1, 0, 0);
      chk("wash_pause", 30, 57, 5, 4, 0);
      for (int i = 0; i < 3; i++) begin
         apply(0, 1, 0, 1, 0);
         chk($sformatf("wash_paused_tick%0d", i), 30, 57, 5, 4, 0);
      end
      apply(0, 1, 1, 0, 0);
      chk("wash_resume", 30, 4, 5, 4, 0);

      run_ticks(11, 26, "to_rinse");
      apply(0, 0, 0, 1, 0);
      chk("power_drop", 55, 55, 55, 0, 0);
      apply(0, 1, 0, 0, 0);
      chk("repower_lamp", 56, 56, 56, 1, 0);
      apply(0, 1, 0, 1, 0);
      chk("repower_lamp_t1", 56, 56, 56, 1, 0);
      apply(0, 1, 0, 1, 0);
      chk("repower_idle", 40, 0, 0, 2, 0);

      apply(0, 1, 1, 0, 0);
      chk("run2_fill1", 40, 5, 0, 3, 0);
      run_ticks(1, 37, "run2");
      apply(0, 1, 0, 0, 1);
      chk("spin_lid_open", 3, 57, 0, 9, 0);
      apply(0, 1, 1, 0, 1);
      chk("spin_start_lid", 3, 57, 0, 9, 0);
      apply(0, 1, 0, 1, 1);
      chk("spin_tick_lid", 3, 57, 0, 9, 0);
      apply(0, 1, 0, 0, 0);
      chk("spin_lid_closed", 3, 57, 0, 9, 0);
      apply(0, 1, 1, 0, 0);
      chk("spin_resume", 3, 3, 0, 9, 0);
      run_ticks(38, 40, "run2");
      apply(0, 1, 0, 0, 0);
      chk("done_hold", 0, 0, 0, 10, 0);
      apply(0, 1, 0, 1, 0);
      chk("done_tick", 0, 0, 0, 10, 0);
      apply(0, 1, 1, 0, 0);
      chk("done_to_idle", 40, 0, 0, 2, 0);

      apply(0, 1, 1, 0, 0);
      chk("run3_fill1", 40, 5, 0, 3, 0);
      run_ticks(1, 40, "run3");
      apply(0, 1, 0, 0, 0);
      chk("run3_done_hold", 0, 0, 0, 10, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
